// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the two-requester memory port arbiter: fetch (m0), load/store (m1) and memory side.
// slave is the arbiter's view; master is the view of the requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic              m0_gnt_o;
    logic              m0_rvalid_o;
    logic [DATA_W-1:0] m0_rdata_o;
    logic              m0_err_o;

    logic              m1_req_i;
    logic              m1_we_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_wdata_i;
    logic [1:0]        m1_size_i;
    logic              m1_gnt_o;
    logic              m1_rvalid_o;
    logic [DATA_W-1:0] m1_rdata_o;
    logic              m1_err_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [1:0]        mem_size_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  m0_req_i, m0_addr_i,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_size_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_size_o
    );

    modport master (
        output m0_req_i, m0_addr_i,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_size_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_size_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one request/grant/response memory port between fetch (m0) and
// load/store (m1), with one transaction in flight and a response timeout that returns an error.
//
// state    | meaning
// IDLE     | no transaction; grant a requester combinationally
// ISSUE    | mem_req_o high with latched payload, waiting for mem_gnt_i
// WAIT_RSP | request accepted, waiting for mem_rvalid_i
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic clk_i,
    input  logic reset_ni,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ISSUE    = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;

    // One spare count of headroom so a saturated counter still compares as expired
    localparam int              CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);

    logic [1:0]        state;
    logic              owner;
    logic              last_owner;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;

    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        size_q;

    logic              rvalid0_q, rvalid1_q;
    logic              err0_q, err1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic gnt0, gnt1, busy, to_hit, rsp_ok, to_err, deliver;

    // Grants are gated by reset so every output reads 0 while reset_ni is low
    assign gnt0 = reset_ni && (state == IDLE) && bus.m0_req_i && (!bus.m1_req_i || last_owner);
    assign gnt1 = reset_ni && (state == IDLE) && bus.m1_req_i && (!bus.m0_req_i || !last_owner);

    assign busy    = (state == ISSUE) || (state == WAIT_RSP);
    assign cnt_inc = cnt + CNT_W'(1);
    assign to_hit  = (TIMEOUT != 0) && (cnt_inc >= TO_V);
    assign rsp_ok  = (state == WAIT_RSP) && bus.mem_rvalid_i;
    assign to_err  = busy && to_hit && !rsp_ok && !((state == ISSUE) && bus.mem_gnt_i);
    assign deliver = rsp_ok || to_err;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cnt        <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= 2'b00;
        end else begin
            if (busy) begin
                cnt <= to_hit ? TO_V : cnt_inc;
            end
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        owner      <= gnt1;
                        last_owner <= gnt1;
                        cnt        <= '0;
                        req_q      <= 1'b1;
                        state      <= ISSUE;
                        if (gnt1) begin
                            we_q    <= bus.m1_we_i;
                            addr_q  <= bus.m1_addr_i;
                            wdata_q <= bus.m1_wdata_i;
                            size_q  <= bus.m1_size_i;
                        end else begin
                            we_q    <= 1'b0;
                            addr_q  <= bus.m0_addr_i;
                            wdata_q <= '0;
                            size_q  <= 2'b10;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_gnt_i) begin
                        req_q <= 1'b0;
                        state <= WAIT_RSP;
                    end else if (to_err) begin
                        req_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                WAIT_RSP: begin
                    if (deliver) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    req_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Response path: only the owner's registers move; rdata holds between pulses
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            if (deliver) begin
                if (owner) begin
                    rvalid1_q <= 1'b1;
                    err1_q    <= to_err;
                    rdata1_q  <= to_err ? '0 : bus.mem_rdata_i;
                end else begin
                    rvalid0_q <= 1'b1;
                    err0_q    <= to_err;
                    rdata0_q  <= to_err ? '0 : bus.mem_rdata_i;
                end
            end
        end
    end

    assign bus.m0_gnt_o    = gnt0;
    assign bus.m1_gnt_o    = gnt1;
    assign bus.m0_rvalid_o = rvalid0_q;
    assign bus.m1_rvalid_o = rvalid1_q;
    assign bus.m0_err_o    = err0_q;
    assign bus.m1_err_o    = err1_q;
    assign bus.m0_rdata_o  = rdata0_q;
    assign bus.m1_rdata_o  = rdata1_q;

    assign bus.mem_req_o   = req_q;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.mem_size_o  = size_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m0_req_i = 0; bus.m0_addr_i = '0;
        bus.m1_req_i = 0; bus.m1_we_i = 0; bus.m1_addr_i = '0; bus.m1_wdata_i = '0; bus.m1_size_i = 2'b00;
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #12;
        checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req_o); end
        checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr_o); end
        checks++; if ({bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m0_err_o, bus.m1_err_o} !== 4'b0) begin errors++; $display("FAIL reset_rsp got %b want 0000", {bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m0_err_o, bus.m1_err_o}); end
        bus.m0_req_i = 1;
        #1;
        checks++; if (bus.m0_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt_gated got %b want 0", bus.m0_gnt_o); end
        bus.m0_req_i = 0;
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_single_fetch();
        bus.m0_req_i = 1; bus.m0_addr_i = 32'h0001_0000;
        @(negedge clk);
        checks++; if ({bus.m0_gnt_o, bus.m1_gnt_o, bus.mem_req_o} !== 3'b100) begin errors++; $display("FAIL fetch_c0 gnt0/gnt1/req got %b want 100", {bus.m0_gnt_o, bus.m1_gnt_o, bus.mem_req_o}); end
        tick(); bus.m0_req_i = 0; bus.mem_gnt_i = 1;
        @(negedge clk);
        checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h0001_0000) begin errors++; $display("FAIL fetch_c1 req %b addr %h want 1 00010000", bus.mem_req_o, bus.mem_addr_o); end
        checks++; if (bus.mem_we_o !== 1'b0 || bus.mem_size_o !== 2'b10 || bus.mem_wdata_o !== 32'h0) begin errors++; $display("FAIL fetch_payload we %b size %b wdata %h want 0 10 0", bus.mem_we_o, bus.mem_size_o, bus.mem_wdata_o); end
        tick(); bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h0000_0013;
        @(negedge clk);
        checks++; if (bus.mem_req_o !== 1'b0 || bus.m0_rvalid_o !== 1'b0) begin errors++; $display("FAIL fetch_c2 req %b rvalid %b want 0 0", bus.mem_req_o, bus.m0_rvalid_o); end
        tick(); bus.mem_rvalid_i = 0; bus.mem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (bus.m0_rvalid_o !== 1'b1 || bus.m0_rdata_o !== 32'h13 || bus.m0_err_o !== 1'b0 || bus.m1_rvalid_o !== 1'b0) begin errors++; $display("FAIL fetch_rsp rvalid %b rdata %h err %b m1v %b want 1 00000013 0 0", bus.m0_rvalid_o, bus.m0_rdata_o, bus.m0_err_o, bus.m1_rvalid_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.m0_rvalid_o !== 1'b0 || bus.m0_rdata_o !== 32'h13) begin errors++; $display("FAIL fetch_hold rvalid %b rdata %h want 0 00000013", bus.m0_rvalid_o, bus.m0_rdata_o); end
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.m0_req_i = 1; bus.m0_addr_i = 32'h0002_0000;
        bus.m1_req_i = 1; bus.m1_we_i = 1; bus.m1_addr_i = 32'h100; bus.m1_wdata_i = 32'hDEAD_BEEF; bus.m1_size_i = 2'b10;
        @(negedge clk);
        checks++; if ({bus.m0_gnt_o, bus.m1_gnt_o} !== 2'b10) begin errors++; $display("FAIL tie_first got %b want 10", {bus.m0_gnt_o, bus.m1_gnt_o}); end
        tick(); bus.mem_gnt_i = 1;
        @(negedge clk);
        checks++; if (bus.mem_addr_o !== 32'h0002_0000 || {bus.m0_gnt_o, bus.m1_gnt_o} !== 2'b00) begin errors++; $display("FAIL tie_issue0 addr %h gnt %b want 00020000 00", bus.mem_addr_o, {bus.m0_gnt_o, bus.m1_gnt_o}); end
        tick(); bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hAAAA_0001;
        tick(); bus.mem_rvalid_i = 0;
        @(negedge clk);
        checks++; if ({bus.m0_rvalid_o, bus.m0_gnt_o, bus.m1_gnt_o} !== 3'b101) begin errors++; $display("FAIL tie_second rv0/gnt0/gnt1 got %b want 101", {bus.m0_rvalid_o, bus.m0_gnt_o, bus.m1_gnt_o}); end
        tick(); bus.m0_req_i = 0; bus.m1_req_i = 0; bus.mem_gnt_i = 1;
        @(negedge clk);
        checks++; if (bus.mem_we_o !== 1'b1 || bus.mem_wdata_o !== 32'hDEAD_BEEF || bus.mem_addr_o !== 32'h100 || bus.mem_size_o !== 2'b10) begin errors++; $display("FAIL write_issue we %b wdata %h addr %h size %b want 1 deadbeef 00000100 10", bus.mem_we_o, bus.mem_wdata_o, bus.mem_addr_o, bus.mem_size_o); end
        tick(); bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h0;
        tick(); bus.mem_rvalid_i = 0;
        @(negedge clk);
        checks++; if ({bus.m1_rvalid_o, bus.m1_err_o, bus.m0_rvalid_o} !== 3'b100) begin errors++; $display("FAIL write_rsp rv1/err1/rv0 got %b want 100", {bus.m1_rvalid_o, bus.m1_err_o, bus.m0_rvalid_o}); end
        tick();
    endtask

    task automatic test_fairness();
        bus.m0_req_i = 1; bus.m0_addr_i = 32'h0003_0000;
        bus.m1_req_i = 1; bus.m1_we_i = 0; bus.m1_addr_i = 32'h180;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if ({bus.m0_gnt_o, bus.m1_gnt_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL fair_grant%0d got %b want %b", i, {bus.m0_gnt_o, bus.m1_gnt_o}, (i % 2 == 0) ? 2'b10 : 2'b01); end
            tick(); bus.mem_gnt_i = 1;
            @(negedge clk);
            checks++; if ({bus.m0_gnt_o, bus.m1_gnt_o} !== 2'b00) begin errors++; $display("FAIL fair_nogrant%0d got %b want 00", i, {bus.m0_gnt_o, bus.m1_gnt_o}); end
            tick(); bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h100 + i;
            tick(); bus.mem_rvalid_i = 0;
            if (i == 5) begin
                bus.m0_req_i = 0; bus.m1_req_i = 0;
            end
        end
        @(negedge clk);
        checks++; if ({bus.m1_rvalid_o, bus.m1_rdata_o} !== {1'b1, 32'h105}) begin errors++; $display("FAIL fair_last_rsp rv1 %b rdata %h want 1 00000105", bus.m1_rvalid_o, bus.m1_rdata_o); end
        checks++; if (bus.m0_rdata_o !== 32'h104) begin errors++; $display("FAIL fair_m0_hold rdata %h want 00000104", bus.m0_rdata_o); end
        tick();
    endtask

    task automatic test_stall();
        bus.m1_req_i = 1; bus.m1_we_i = 0; bus.m1_addr_i = 32'h203; bus.m1_wdata_i = '0; bus.m1_size_i = 2'b00;
        @(negedge clk);
        checks++; if (bus.m1_gnt_o !== 1'b1) begin errors++; $display("FAIL stall_gnt got %b want 1", bus.m1_gnt_o); end
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            checks++; if ({bus.mem_req_o, bus.mem_addr_o, bus.mem_size_o, bus.m1_gnt_o} !== {1'b1, 32'h203, 2'b00, 1'b0}) begin errors++; $display("FAIL stall_hold%0d req %b addr %h size %b gnt1 %b want 1 00000203 00 0", k, bus.mem_req_o, bus.mem_addr_o, bus.mem_size_o, bus.m1_gnt_o); end
        end
        tick(); bus.m1_req_i = 0; bus.mem_gnt_i = 1;
        tick(); bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h0000_0055;
        @(negedge clk);
        checks++; if (bus.m1_rvalid_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL stall_wait rv1 %b req %b want 0 0", bus.m1_rvalid_o, bus.mem_req_o); end
        tick(); bus.mem_rvalid_i = 0;
        @(negedge clk);
        checks++; if ({bus.m1_rvalid_o, bus.m1_err_o, bus.m1_rdata_o, bus.m0_rvalid_o} !== {1'b1, 1'b0, 32'h55, 1'b0}) begin errors++; $display("FAIL stall_rsp rv1 %b err %b rdata %h rv0 %b want 1 0 00000055 0", bus.m1_rvalid_o, bus.m1_err_o, bus.m1_rdata_o, bus.m0_rvalid_o); end
        tick();
    endtask

    task automatic test_timeout();
        bus.m1_req_i = 1; bus.m1_addr_i = 32'h300; bus.m1_size_i = 2'b10;
        @(negedge clk);
        checks++; if (bus.m1_gnt_o !== 1'b1) begin errors++; $display("FAIL to_gnt got %b want 1", bus.m1_gnt_o); end
        tick(); bus.m1_req_i = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++; if ({bus.mem_req_o, bus.m1_rvalid_o} !== 2'b10) begin errors++; $display("FAIL to_busy%0d req/rv1 got %b want 10", k, {bus.mem_req_o, bus.m1_rvalid_o}); end
            tick();
        end
        @(negedge clk);
        checks++; if ({bus.mem_req_o, bus.m1_rvalid_o, bus.m1_err_o, bus.m1_rdata_o} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL to_err req %b rv1 %b err %b rdata %h want 0 1 1 00000000", bus.mem_req_o, bus.m1_rvalid_o, bus.m1_err_o, bus.m1_rdata_o); end
        tick(); bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h0000_0077;
        tick(); bus.mem_rvalid_i = 0;
        @(negedge clk);
        checks++; if ({bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m1_rdata_o} !== {2'b00, 32'h0}) begin errors++; $display("FAIL to_stray rv0/rv1 %b rdata1 %h want 00 00000000", {bus.m0_rvalid_o, bus.m1_rvalid_o}, bus.m1_rdata_o); end
        tick();
    endtask

    task automatic test_async_reset();
        bus.m0_req_i = 1; bus.m0_addr_i = 32'h400;
        tick(); bus.m0_req_i = 0; bus.mem_gnt_i = 1;
        tick(); bus.mem_gnt_i = 0;
        #3;
        bus.m0_req_i = 1; bus.m0_addr_i = 32'h500;
        bus.m1_req_i = 1; bus.m1_addr_i = 32'h600;
        rst_n = 0;
        #1;
        checks++; if ({bus.mem_req_o, bus.m0_gnt_o, bus.m1_gnt_o, bus.mem_addr_o, bus.m0_rdata_o} !== {3'b000, 32'h0, 32'h0}) begin errors++; $display("FAIL areset_outs req/gnt %b addr %h rdata0 %h want 000 0 0", {bus.mem_req_o, bus.m0_gnt_o, bus.m1_gnt_o}, bus.mem_addr_o, bus.m0_rdata_o); end
        tick(); bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h0000_0099;
        @(negedge clk);
        checks++; if ({bus.m0_rvalid_o, bus.m1_rvalid_o} !== 2'b00) begin errors++; $display("FAIL areset_in_reset rv got %b want 00", {bus.m0_rvalid_o, bus.m1_rvalid_o}); end
        #1 rst_n = 1;
        #1;
        checks++; if ({bus.m0_gnt_o, bus.m1_gnt_o} !== 2'b10) begin errors++; $display("FAIL areset_tie got %b want 10", {bus.m0_gnt_o, bus.m1_gnt_o}); end
        tick(); bus.mem_rvalid_i = 0; bus.m0_req_i = 0; bus.m1_req_i = 0;
        @(negedge clk);
        checks++; if ({bus.m0_rvalid_o, bus.m1_rvalid_o, bus.mem_req_o, bus.mem_addr_o} !== {3'b001, 32'h500}) begin errors++; $display("FAIL areset_after rv0/rv1/req %b addr %h want 001 00000500", {bus.m0_rvalid_o, bus.m1_rvalid_o, bus.mem_req_o}, bus.mem_addr_o); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_fairness();
        test_stall();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
